host_cmd_frontend: RTL

Host-side command intake for the DDR3 memory controller: the responder to the 34-bit command/valid/write_data interface issued by host agents and test patterns. It buffers accepted commands with their write data in an in-order queue and reports per-bank readiness on `ba_cmd_pm`. It issues commands to the controller backend, and returns backend read data to the host as `read_data`/`read_data_valid`. It sits between the host interface and the bank scheduler.

---
 rtl/host_cmd_frontend.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/host_cmd_frontend.sv
// host_cmd_frontend
//   Host-side command intake for the DDR3 controller. Accepted host commands
//   and their write data are held in an in-order queue and presented to the
//   backend. Per-bank counters track commands that are queued or in flight.
//   A tag FIFO remembers the bank of every read issued to the backend so that
//   returning read data can retire the matching bank count.
//
// Ports
//   clk             controller clock, all logic on posedge
//   power_on_rst_n  asynchronous active-low reset
//   command[33:0]   {rank, rw, 0, row, 0, bl, 0, auto_pre, col, bank}
//   valid           command / write_data qualifier
//   write_data      write data accompanying command
//   ba_cmd_pm[7:0]  per-bank "a command to this bank is accepted now"
//   read_data       last returned read beat
//   read_data_valid one-cycle pulse per returned read beat
//   be_cmd/be_wdata queue head towards the backend (zero when queue empty)
//   be_valid        head is issuable
//   be_ready        backend takes the head on be_valid & be_ready
//   be_rdata(_valid) backend read return, in issue order
//   drop_err        sticky protocol-error flag
//
// Optional build macro FRONTEND_STATUS_EN adds the status outputs
//   q_level         current queue occupancy
//   drop_cnt        saturating count of error events
module host_cmd_frontend #(
  parameter int DATA_W   = 128,
  parameter int DEPTH    = 8,
  parameter int BANK_MAX = 4,
  parameter int RD_OUT   = 8
) (
  input  logic                     clk,
  input  logic                     power_on_rst_n,
  input  logic [33:0]              command,
  input  logic                     valid,
  input  logic [DATA_W-1:0]        write_data,
  output logic [7:0]               ba_cmd_pm,
  output logic [DATA_W-1:0]        read_data,
  output logic                     read_data_valid,
  output logic [33:0]              be_cmd,
  output logic [DATA_W-1:0]        be_wdata,
  output logic                     be_valid,
  input  logic                     be_ready,
  input  logic [DATA_W-1:0]        be_rdata,
  input  logic                     be_rdata_valid,
`ifdef FRONTEND_STATUS_EN
  output logic [$clog2(DEPTH):0]   q_level,
  output logic [7:0]               drop_cnt,
`endif
  output logic                     drop_err
);

  localparam int QW    = $clog2(DEPTH);
  localparam int TW    = $clog2(RD_OUT);
  localparam int NBANK = 8;

  // Saturating add used by the error-event counter.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Command queue storage (data only, no reset) and pointers with wrap bit.
  logic [33:0]       q_cmd [DEPTH];
  logic [DATA_W-1:0] q_wd  [DEPTH];
  logic [QW:0]       q_wr, q_rd;
  logic              q_empty, q_full;

  // Tag FIFO of banks for reads awaiting data.
  logic [2:0]        tag_mem [RD_OUT];
  logic [TW:0]       t_wr, t_rd;
  logic              tag_empty, tag_full;

  logic [3:0]        cnt     [NBANK];
  logic [3:0]        cnt_nxt [NBANK];

  logic [33:0]       head_cmd;
  logic              head_rw;
  logic [2:0]        head_bank, acc_bank, ret_bank;
  logic              accept, drop_cmd, issue, issue_wr, issue_rd, ret_ok, ret_bad;

  assign q_empty   = (q_wr == q_rd);
  assign q_full    = (q_wr[QW] != q_rd[QW]) && (q_wr[QW-1:0] == q_rd[QW-1:0]);
  assign tag_empty = (t_wr == t_rd);
  assign tag_full  = (t_wr[TW] != t_rd[TW]) && (t_wr[TW-1:0] == t_rd[TW-1:0]);

  assign head_cmd  = q_cmd[q_rd[QW-1:0]];
  assign head_rw   = head_cmd[31];
  assign head_bank = head_cmd[2:0];
  assign ret_bank  = tag_mem[t_rd[TW-1:0]];
  assign acc_bank  = command[2:0];

  // Empty queue shows zeros so the head never exposes stale storage.
  assign be_cmd    = q_empty ? '0 : head_cmd;
  assign be_wdata  = q_empty ? '0 : q_wd[q_rd[QW-1:0]];
  // A read at the head waits until a tag slot is free for its return.
  assign be_valid  = !q_empty && (!head_rw || !tag_full);

  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      ba_cmd_pm[b] = !q_full && (cnt[b] < 4'(BANK_MAX));
    end
  end

  assign accept   = valid && ba_cmd_pm[acc_bank];
  assign drop_cmd = valid && !ba_cmd_pm[acc_bank];
  assign issue    = be_valid && be_ready;
  assign issue_wr = issue && !head_rw;
  assign issue_rd = issue && head_rw;
  assign ret_ok   = be_rdata_valid && !tag_empty;
  assign ret_bad  = be_rdata_valid && tag_empty;

  // Up to one increment and two decrements (write issue, read return) per bank.
  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      cnt_nxt[b] = cnt[b];
      if (accept   && (acc_bank  == 3'(b))) cnt_nxt[b] = cnt_nxt[b] + 4'd1;
      if (issue_wr && (head_bank == 3'(b))) cnt_nxt[b] = cnt_nxt[b] - 4'd1;
      if (ret_ok   && (ret_bank  == 3'(b))) cnt_nxt[b] = cnt_nxt[b] - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      q_cmd[q_wr[QW-1:0]] <= command;
      q_wd[q_wr[QW-1:0]]  <= write_data;
    end
    if (issue_rd) begin
      tag_mem[t_wr[TW-1:0]] <= head_bank;
    end
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      q_wr            <= '0;
      q_rd            <= '0;
      t_wr            <= '0;
      t_rd            <= '0;
      for (int b = 0; b < NBANK; b++) cnt[b] <= '0;
      read_data       <= '0;
      read_data_valid <= 1'b0;
      drop_err        <= 1'b0;
    end else begin
      if (accept)   q_wr <= q_wr + {{QW{1'b0}}, 1'b1};
      if (issue)    q_rd <= q_rd + {{QW{1'b0}}, 1'b1};
      if (issue_rd) t_wr <= t_wr + {{TW{1'b0}}, 1'b1};
      if (ret_ok)   t_rd <= t_rd + {{TW{1'b0}}, 1'b1};
      for (int b = 0; b < NBANK; b++) cnt[b] <= cnt_nxt[b];
      if (ret_ok)   read_data <= be_rdata;
      read_data_valid <= ret_ok;
      if (drop_cmd || ret_bad) drop_err <= 1'b1;
    end
  end

`ifdef FRONTEND_STATUS_EN
  assign q_level = q_wr - q_rd;

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      drop_cnt <= '0;
    end else begin
      // A dropped command and a spurious return can coincide: count both.
      drop_cnt <= sat_add8(drop_cnt, {1'b0, drop_cmd} + {1'b0, ret_bad});
    end
  end
`endif

endmodule
